// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the default operand width.
package serial_adder_pkg;

  localparam int SA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the serial adder's per-bit datapath.
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ carry_in;
  assign carry = (a & b) | (carry_in & (a ^ b));

endmodule : Full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: computes a + b + carry_in one bit per clock, LSB first,
// through a single full adder. Result and carry are published in the one-cycle
// DONE state and held until the next completion.
// Optional feature: define SERIAL_ADDER_OVERFLOW_EN to add the signed
// overflow output (carry into MSB XOR carry out of MSB).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_d;
  logic               c_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_out_q;
  logic               fa_sum;
  logic               fa_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic               overflow_q;
`endif

  Full_adder u_fa (
    .a        (a_q[0]),
    .b        (b_q[0]),
    .carry_in (c_q),
    .sum      (fa_sum),
    .carry    (fa_carry)
  );

  // Result register shifts right with the new sum bit entering at the MSB;
  // after WIDTH steps the LSB-first bits sit in their natural positions.
  assign res_d = WIDTH'({fa_sum, res_q} >> 1);

  // Control FSM and serial datapath: load on accepted start, one bit per
  // SHIFT cycle, publish the result on the transition into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            res_q   <= '0;
            c_q     <= carry_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          c_q   <= fa_carry;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            sum_q       <= res_d;
            carry_out_q <= fa_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            // c_q holds the carry into the MSB during the final step.
            overflow_q  <= c_q ^ fa_carry;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign overflow  = overflow_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance for directed and
// table-driven cases, a 4-bit instance for the exhaustive back-to-back sweep.
// Expected results are queued when a start is driven and compared when done
// pulses. Edge numbering for latency: start is driven just after edge 0.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic       ovf8, ovf4;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp8_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  exp8_t      q8[$];
  logic [5:0] q4[$];   // {ovf, cout, sum}
  vec_t       vecs[6];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .carry_in  (cin8),
    .busy      (busy8),
    .done      (done8),
    .sum       (sum8),
    .carry_out (cout8)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow  (ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .a         (a4),
    .b         (b4),
    .carry_in  (cin4),
    .busy      (busy4),
    .done      (done4),
    .sum       (sum4),
    .carry_out (cout4)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow  (ovf4)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard for the 8-bit instance
  always @(negedge clk) begin : mon8
    exp8_t e;
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 32'(done8), 32'd0);
      end else begin
        e = q8.pop_front();
        chk("sum8", 32'(sum8), 32'(e.s));
        chk("cout8", 32'(cout8), 32'(e.c));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("ovf8", 32'(ovf8), 32'(e.o));
`endif
      end
    end
  end

  // Scoreboard for the 4-bit instance
  always @(negedge clk) begin : mon4
    logic [5:0] e;
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        chk("done4_unexpected", 32'(done4), 32'd0);
      end else begin
        e = q4.pop_front();
        chk("sum4", 32'(sum4), 32'(e[3:0]));
        chk("cout4", 32'(cout4), 32'(e[4]));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("ovf4", 32'(ovf4), 32'(e[5]));
`endif
      end
    end
  end

  // Drive one start on the 8-bit DUT and queue its expected result;
  // operands are scrambled right after acceptance.
  task automatic start8_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                           input logic [7:0] es, input logic ec, input logic eo);
    exp8_t e;
    @(posedge clk); #1;
    a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
    e.s = es; e.c = ec; e.o = eo;
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic wait_done8(input int max);
    bit seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    chk("done8_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_done4(input int max);
    bit seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    chk("done4_seen", 32'(seen), 32'd1);
  endtask

  // Set up 4-bit operands from a 9-bit index and queue the reference result.
  task automatic load4(input int idx);
    logic [4:0] full;
    logic [3:0] low;
    logic       c3;
    a4   = 4'(idx >> 5);
    b4   = 4'(idx >> 1);
    cin4 = 1'(idx);
    full = {1'b0, a4} + {1'b0, b4} + 5'(cin4);
    low  = {1'b0, a4[2:0]} + {1'b0, b4[2:0]} + 4'(cin4);
    c3   = low[3];
    q4.push_back({c3 ^ full[4], full});
    start4 = 1'b1;
  endtask

  initial begin
    int  busy_cnt, done_k, hold_bad, done_cnt, b2b_bad;

    vecs[0] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1, o: 1'b0};
    vecs[1] = '{a: 8'h55, b: 8'hAA, cin: 1'b1, s: 8'h00, c: 1'b1, o: 1'b0};
    vecs[2] = '{a: 8'h12, b: 8'h34, cin: 1'b0, s: 8'h46, c: 1'b0, o: 1'b0};
    vecs[3] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, c: 1'b0, o: 1'b1};
    vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, c: 1'b1, o: 1'b1};
    vecs[5] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, c: 1'b0, o: 1'b0};

    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    a4 = 4'h0;  b4 = 4'h0;  cin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);

    // Latency and busy width: FF + 01
    start8_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    busy_cnt = 0; done_k = -1; hold_bad = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (busy8) begin
        busy_cnt++;
        if (sum8 !== 8'h00 || cout8 !== 1'b0) hold_bad++;
      end
      if (done8 && done_k < 0) done_k = k;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd8);
    chk("done_latency", 32'(done_k), 32'd9);
    chk("sum_hold_during_shift", 32'(hold_bad), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      start8_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, vecs[i].o);
      wait_done8(20);
    end

    // Start pulsed during SHIFT cycle 3 is ignored
    start8_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    a8 = 8'hF0; b8 = 8'hF0; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done8) done_cnt++;
    end
    chk("single_done_pulse", 32'(done_cnt), 32'd1);

    // Reset during SHIFT cycle 4 aborts the operation
    @(posedge clk); #1;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_sum", 32'(sum8), 32'd0);
    chk("abort_cout", 32'(cout8), 32'd0);
    start8_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    wait_done8(20);

    // Exhaustive 4-bit sweep, each new start issued during DONE
    b2b_bad = 0;
    @(posedge clk); #1;
    load4(0);
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int i = 1; i < 512; i++) begin
      wait_done4(12);
      load4(i);
      @(posedge clk); #1;
      start4 = 1'b0;
      @(negedge clk);
      if (busy4 !== 1'b1) b2b_bad++;
    end
    wait_done4(12);
    chk("b2b_busy_after_done", 32'(b2b_bad), 32'd0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_serial_adder
